// File: rtl/card_sprite_reader.sv
// Card-back sprite read client: scan-to-address mapping, frame-synchronous position commit and key-colour merge.
// Optional build macro SPRITE_HFLIP_EN adds an hflip input that mirrors the sprite horizontally.
module card_sprite_reader #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 11,
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 64,
    parameter int CORD_W     = 11,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR = 12'hF0F
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CORD_W-1:0]     x,
    input  logic [CORD_W-1:0]     y,
    input  logic                  frame_start,
    input  logic [DATA_WIDTH-1:0] bg_rgb,
    input  logic                  sprite_en,
    input  logic                  pos_wr,
    input  logic [CORD_W-1:0]     pos_x,
    input  logic [CORD_W-1:0]     pos_y,
`ifdef SPRITE_HFLIP_EN
    input  logic                  hflip,
`endif
    output logic                  pos_ack,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] rgb_out,
    output logic                  hit
);

    localparam int XB = $clog2(SPR_W);
    localparam int YB = $clog2(SPR_H);
    localparam logic [CORD_W:0] SPR_W_EXT = (CORD_W+1)'(SPR_W);
    localparam logic [CORD_W:0] SPR_H_EXT = (CORD_W+1)'(SPR_H);

    typedef enum logic {IDLE, PENDING} pos_state_t;

    pos_state_t        state, state_nxt;
    logic [CORD_W-1:0] pend_x, pend_y, pend_x_nxt, pend_y_nxt;
    logic [CORD_W-1:0] act_x, act_y, act_x_nxt, act_y_nxt;
    logic              pend_hf, pend_hf_nxt, act_hf, act_hf_nxt;
    logic              req_hf;
    logic              commit;

`ifdef SPRITE_HFLIP_EN
    assign req_hf = hflip;
`else
    assign req_hf = 1'b0;
`endif

    // A write coinciding with frame_start bypasses the pending slot and commits directly.
    always_comb begin
        state_nxt   = state;
        pend_x_nxt  = pend_x;
        pend_y_nxt  = pend_y;
        pend_hf_nxt = pend_hf;
        act_x_nxt   = act_x;
        act_y_nxt   = act_y;
        act_hf_nxt  = act_hf;
        commit      = 1'b0;
        if (frame_start && pos_wr) begin
            act_x_nxt  = pos_x;
            act_y_nxt  = pos_y;
            act_hf_nxt = req_hf;
            commit     = 1'b1;
            state_nxt  = IDLE;
        end else if (frame_start && state == PENDING) begin
            act_x_nxt  = pend_x;
            act_y_nxt  = pend_y;
            act_hf_nxt = pend_hf;
            commit     = 1'b1;
            state_nxt  = IDLE;
        end else if (pos_wr) begin
            pend_x_nxt  = pos_x;
            pend_y_nxt  = pos_y;
            pend_hf_nxt = req_hf;
            state_nxt   = PENDING;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pend_x  <= '0;
            pend_y  <= '0;
            pend_hf <= 1'b0;
            act_x   <= '0;
            act_y   <= '0;
            act_hf  <= 1'b0;
            pos_ack <= 1'b0;
        end else begin
            state   <= state_nxt;
            pend_x  <= pend_x_nxt;
            pend_y  <= pend_y_nxt;
            pend_hf <= pend_hf_nxt;
            act_x   <= act_x_nxt;
            act_y   <= act_y_nxt;
            act_hf  <= act_hf_nxt;
            pos_ack <= commit;
        end
    end

    // Stage 0: region limits are one bit wider so a card past the screen edge never wraps.
    logic [CORD_W:0]   x_lim, y_lim;
    logic [CORD_W-1:0] dx, dy;
    logic [XB-1:0]     col;
    logic              in_rgn_p0;

    assign x_lim     = {1'b0, act_x} + SPR_W_EXT;
    assign y_lim     = {1'b0, act_y} + SPR_H_EXT;
    assign in_rgn_p0 = (x >= act_x) && ({1'b0, x} < x_lim) &&
                       (y >= act_y) && ({1'b0, y} < y_lim);
    assign dx        = x - act_x;
    assign dy        = y - act_y;
    // SPR_W is a power of two, so SPR_W-1-c is the bitwise inverse of c.
    assign col       = dx[XB-1:0] ^ {XB{act_hf}};
    assign ram_addr  = {dy[YB-1:0], col};

    // Stage 1: align control and background with the RAM's registered read.
    logic                  in_rgn_p1, en_p1;
    logic [DATA_WIDTH-1:0] bg_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_rgn_p1 <= 1'b0;
            en_p1     <= 1'b0;
            bg_p1     <= '0;
        end else begin
            in_rgn_p1 <= in_rgn_p0;
            en_p1     <= sprite_en;
            bg_p1     <= bg_rgb;
        end
    end

    // Stage 2: key-colour merge.
    logic opaque_p1;
    assign opaque_p1 = in_rgn_p1 && en_p1 && (ram_dout != KEY_COLOR);

    always_ff @(posedge clk) begin
        if (reset) begin
            hit     <= 1'b0;
            rgb_out <= '0;
        end else begin
            hit     <= opaque_p1;
            rgb_out <= opaque_p1 ? ram_dout : bg_p1;
        end
    end

endmodule

// File: tb/tb_card_sprite_reader.sv
// Directed self-checking bench for card_sprite_reader with a behavioural 1-cycle registered sprite RAM.
module tb_card_sprite_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x, y, pos_x, pos_y;
    logic        frame_start, sprite_en, pos_wr;
    logic [11:0] bg_rgb, ram_dout, rgb_out;
    logic [10:0] ram_addr;
    logic        pos_ack, hit;
`ifdef SPRITE_HFLIP_EN
    logic        hflip;
`endif

    int checks = 0;
    int errors = 0;

    logic [11:0] mem [0:2047];

    always #5 clk = ~clk;

    // Sprite RAM model: word i holds i (never the key colour) except the patched words.
    always @(posedge clk) ram_dout <= mem[ram_addr];

    card_sprite_reader dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .frame_start(frame_start),
        .bg_rgb(bg_rgb), .sprite_en(sprite_en), .pos_wr(pos_wr),
        .pos_x(pos_x), .pos_y(pos_y),
`ifdef SPRITE_HFLIP_EN
        .hflip(hflip),
`endif
        .pos_ack(pos_ack), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .rgb_out(rgb_out), .hit(hit)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; pos_wr = 1'b0; frame_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_pixel(input logic [10:0] px, input logic [10:0] py,
                             input logic [11:0] bg, input logic en);
        @(negedge clk);
        x = px; y = py; bg_rgb = bg; sprite_en = en;
        #1;
    endtask

    // Write a position and commit it at the next frame_start; leaves time just after the commit edge.
    task automatic commit_pos(input logic [10:0] px, input logic [10:0] py);
        @(negedge clk);
        pos_wr = 1'b1; pos_x = px; pos_y = py;
        @(negedge clk);
        pos_wr = 1'b0; frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (hit !== 1'b0 || rgb_out !== 12'h000 || pos_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: hit=%b rgb=%h ack=%b, required 0/000/0", hit, rgb_out, pos_ack);
        end
        @(negedge clk);
        reset = 1'b0;
        set_pixel(11'd3, 11'd2, 12'h111, 1'b1);
        checks++;
        if (ram_addr !== 11'd67) begin
            errors++;
            $display("FAIL reset_addr: ram_addr=%0d, required 67", ram_addr);
        end
    endtask

    task automatic test_commit_and_bounds();
        commit_pos(11'd100, 11'd50);
        checks++;
        if (pos_ack !== 1'b1) begin
            errors++;
            $display("FAIL ack_pulse: pos_ack=%b, required 1", pos_ack);
        end
        @(posedge clk); #1;
        checks++;
        if (pos_ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_single: pos_ack=%b, required 0", pos_ack);
        end
        set_pixel(11'd100, 11'd50, 12'h123, 1'b1);
        checks++;
        if (ram_addr !== 11'd0) begin
            errors++;
            $display("FAIL addr_topleft: ram_addr=%0d, required 0", ram_addr);
        end
        set_pixel(11'd131, 11'd113, 12'h123, 1'b1);
        checks++;
        if (ram_addr !== 11'd2047) begin
            errors++;
            $display("FAIL addr_botright: ram_addr=%0d, required 2047", ram_addr);
        end
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (hit !== 1'b1 || rgb_out !== 12'h7FF) begin
            errors++;
            $display("FAIL pix_botright: hit=%b rgb=%h, required 1/7ff", hit, rgb_out);
        end
        set_pixel(11'd132, 11'd50, 12'h234, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (hit !== 1'b0 || rgb_out !== 12'h234) begin
            errors++;
            $display("FAIL pix_right_out: hit=%b rgb=%h, required 0/234", hit, rgb_out);
        end
        set_pixel(11'd100, 11'd114, 12'h345, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (hit !== 1'b0 || rgb_out !== 12'h345) begin
            errors++;
            $display("FAIL pix_bottom_out: hit=%b rgb=%h, required 0/345", hit, rgb_out);
        end
    endtask

    task automatic test_key_color();
        do_reset();
        set_pixel(11'd5, 11'd0, 12'hABC, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (hit !== 1'b1 || rgb_out !== 12'h0F0) begin
            errors++;
            $display("FAIL opaque_word5: hit=%b rgb=%h, required 1/0f0", hit, rgb_out);
        end
        set_pixel(11'd6, 11'd0, 12'hABC, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (hit !== 1'b0 || rgb_out !== 12'hABC) begin
            errors++;
            $display("FAIL key_word6: hit=%b rgb=%h, required 0/abc", hit, rgb_out);
        end
    endtask

    task automatic test_last_wins();
        int acks = 0;
        commit_pos(11'd100, 11'd50);
        @(negedge clk);
        pos_wr = 1'b1; pos_x = 11'd10; pos_y = 11'd10;
        @(negedge clk);
        pos_x = 11'd20; pos_y = 11'd20;
        @(negedge clk);
        pos_wr = 1'b0;
        x = 11'd100; y = 11'd50;
        #1;
        checks++;
        if (ram_addr !== 11'd0 || pos_ack !== 1'b0) begin
            errors++;
            $display("FAIL pending_old_pos: ram_addr=%0d ack=%b, required 0/0", ram_addr, pos_ack);
        end
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (pos_ack === 1'b1) acks++;
            @(negedge clk);
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL ack_count: acks=%0d, required 1", acks);
        end
        x = 11'd20; y = 11'd20;
        #1;
        checks++;
        if (ram_addr !== 11'd0) begin
            errors++;
            $display("FAIL last_wins_addr: ram_addr=%0d, required 0", ram_addr);
        end
        x = 11'd100; y = 11'd50;
        #1;
        checks++;
        if (ram_addr !== 11'd976) begin
            errors++;
            $display("FAIL last_wins_offset: ram_addr=%0d, required 976", ram_addr);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        pos_wr = 1'b1; frame_start = 1'b1; pos_x = 11'd30; pos_y = 11'd30;
        @(posedge clk); #1;
        pos_wr = 1'b0; frame_start = 1'b0;
        checks++;
        if (pos_ack !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_ack: pos_ack=%b, required 1", pos_ack);
        end
        set_pixel(11'd30, 11'd30, 12'h000, 1'b1);
        checks++;
        if (ram_addr !== 11'd0) begin
            errors++;
            $display("FAIL same_cycle_addr: ram_addr=%0d, required 0", ram_addr);
        end
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        checks++;
        if (pos_ack !== 1'b0) begin
            errors++;
            $display("FAIL idle_frame_ack: pos_ack=%b, required 0", pos_ack);
        end
    endtask

    task automatic test_edge_clip();
        commit_pos(11'd630, 11'd470);
        set_pixel(11'd639, 11'd479, 12'h456, 1'b1);
        checks++;
        if (ram_addr !== 11'd297) begin
            errors++;
            $display("FAIL clip_addr: ram_addr=%0d, required 297", ram_addr);
        end
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (hit !== 1'b1 || rgb_out !== 12'h129) begin
            errors++;
            $display("FAIL clip_pix: hit=%b rgb=%h, required 1/129", hit, rgb_out);
        end
        set_pixel(11'd0, 11'd0, 12'h567, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (hit !== 1'b0 || rgb_out !== 12'h567) begin
            errors++;
            $display("FAIL no_wrap: hit=%b rgb=%h, required 0/567", hit, rgb_out);
        end
        set_pixel(11'd639, 11'd479, 12'h678, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (hit !== 1'b0 || rgb_out !== 12'h678) begin
            errors++;
            $display("FAIL sprite_disabled: hit=%b rgb=%h, required 0/678", hit, rgb_out);
        end
    endtask

    task automatic test_reset_midframe();
        commit_pos(11'd0, 11'd0);
        @(negedge clk);
        pos_wr = 1'b1; pos_x = 11'd200; pos_y = 11'd200;
        x = 11'd5; y = 11'd0; bg_rgb = 12'h789; sprite_en = 1'b1;
        @(negedge clk);
        pos_wr = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (hit !== 1'b0 || rgb_out !== 12'h000) begin
            errors++;
            $display("FAIL reset_flush: hit=%b rgb=%h, required 0/000", hit, rgb_out);
        end
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        checks++;
        if (pos_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard_ack: pos_ack=%b, required 0", pos_ack);
        end
        set_pixel(11'd3, 11'd1, 12'h000, 1'b1);
        checks++;
        if (ram_addr !== 11'd35) begin
            errors++;
            $display("FAIL reset_discard_pos: ram_addr=%0d, required 35", ram_addr);
        end
    endtask

`ifdef SPRITE_HFLIP_EN
    task automatic test_hflip();
        @(negedge clk);
        hflip = 1'b1;
        commit_pos(11'd0, 11'd0);
        hflip = 1'b0;
        set_pixel(11'd0, 11'd0, 12'h000, 1'b1);
        checks++;
        if (ram_addr !== 11'd31) begin
            errors++;
            $display("FAIL hflip_left: ram_addr=%0d, required 31", ram_addr);
        end
        set_pixel(11'd31, 11'd0, 12'h000, 1'b1);
        checks++;
        if (ram_addr !== 11'd0) begin
            errors++;
            $display("FAIL hflip_right: ram_addr=%0d, required 0", ram_addr);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 12'(i);
        mem[5] = 12'h0F0;
        mem[6] = 12'hF0F;
        x = '0; y = '0; pos_x = '0; pos_y = '0;
        frame_start = 1'b0; sprite_en = 1'b0; pos_wr = 1'b0; bg_rgb = '0;
`ifdef SPRITE_HFLIP_EN
        hflip = 1'b0;
`endif
        test_reset();
        test_commit_and_bounds();
        test_key_color();
        test_last_wins();
        test_same_cycle();
        test_edge_clip();
        test_reset_midframe();
`ifdef SPRITE_HFLIP_EN
        test_hflip();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
